// File: rtl/comparator_seq_chunked.sv
// comparator_seq_chunked: multi-cycle magnitude comparator.
// Compares two DATA_WIDTH operands one CHUNK_WIDTH slice per clock, MSB slice
// first, in unsigned or two's-complement mode, with a start/valid handshake.
// Optional build macro: COMPARATOR_SEQ_EARLY_EXIT_EN -- when defined, the scan
// stops on the first differing chunk; results are identical either way.
module comparator_seq_chunked #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Enable_In,
  input  logic                  Clear_In,
  input  logic                  Start_In,
  input  logic                  Signed_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  output logic                  Ready_Out,
  output logic                  Busy_Out,
  output logic                  Valid_Out,
  output logic                  A_gt_B_Out,
  output logic                  A_eq_B_Out,
  output logic                  A_lt_B_Out
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg;
  logic [DATA_WIDTH-1:0]   msb_mask;
  logic                    decided, gt_r, lt_r;
  logic                    gt_q, eq_q, lt_q;
  logic [CHUNK_WIDTH-1:0]  a_chunk, b_chunk;
  logic                    chunk_gt, chunk_lt, chunk_diff;
  logic                    decided_now, scan_end, accept;

  // Current slice compare and end-of-scan decision.
  // Signed mode flips both MSBs at capture so the whole scan stays unsigned.
  always_comb begin
    msb_mask                 = '0;
    msb_mask[DATA_WIDTH-1]   = 1'b1;
    a_chunk     = a_reg[int'(idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
    b_chunk     = b_reg[int'(idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
    chunk_gt    = (a_chunk > b_chunk);
    chunk_lt    = (a_chunk < b_chunk);
    chunk_diff  = chunk_gt | chunk_lt;
    decided_now = decided | chunk_diff;
    scan_end    = (idx == '0) || (EARLY_EXIT && decided_now);
    accept      = (state == IDLE) && Start_In && Enable_In;
  end

  // State register.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic: clear beats stall, stall holds the state.
  always_comb begin
    state_next = state;
    if (Clear_In) begin
      state_next = IDLE;
    end else if (Enable_In) begin
      case (state)
        IDLE:    if (Start_In) state_next = COMPARE;
        COMPARE: if (scan_end) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Handshake outputs are pure state decodes.
  always_comb begin
    Ready_Out = (state == IDLE);
    Busy_Out  = (state == COMPARE) || (state == DONE);
    Valid_Out = (state == DONE);
  end

  // Operand capture, scan progress and result flags.
  // Flags are written on the edge entering DONE so they change with Valid_Out.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      idx     <= LAST_IDX;
      a_reg   <= '0;
      b_reg   <= '0;
      decided <= 1'b0;
      gt_r    <= 1'b0;
      lt_r    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else if (Clear_In) begin
      idx     <= LAST_IDX;
      decided <= 1'b0;
    end else if (Enable_In) begin
      if (accept) begin
        a_reg   <= Signed_In ? (Data_A_In ^ msb_mask) : Data_A_In;
        b_reg   <= Signed_In ? (Data_B_In ^ msb_mask) : Data_B_In;
        idx     <= LAST_IDX;
        decided <= 1'b0;
        gt_r    <= 1'b0;
        lt_r    <= 1'b0;
      end else if (state == COMPARE) begin
        if (!decided && chunk_diff) begin
          decided <= 1'b1;
          gt_r    <= chunk_gt;
          lt_r    <= chunk_lt;
        end
        if (scan_end) begin
          gt_q <= decided ? gt_r : chunk_gt;
          lt_q <= decided ? lt_r : chunk_lt;
          eq_q <= ~decided_now;
        end else begin
          idx <= idx - IDX_W'(1);
        end
      end
    end
  end

  assign A_gt_B_Out = gt_q;
  assign A_eq_B_Out = eq_q;
  assign A_lt_B_Out = lt_q;

endmodule

// File: doc/comparator_seq_chunked.md
Name: comparator_seq_chunked

Overview:
Parametrised, multi-cycle magnitude comparator that succeeds the fixed 32-bit combinational comparator. It compares two DATA_WIDTH operands one CHUNK_WIDTH slice per clock, starting at the MSB slice. It supports unsigned and two's-complement modes and uses a start/valid handshake. It sits in the arithmetic library for wide-operand compares where a single-cycle 32+ bit compare would break timing.

Parameters:
DATA_WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK_WIDTH.
CHUNK_WIDTH, 8, bits compared per cycle; NUM_CHUNKS = DATA_WIDTH/CHUNK_WIDTH is a derived localparam and must be at least 1.

Ports:
Clock_In  input  1  single clock; rising edge.
Reset_In  input  1  asynchronous, active-high reset.
Enable_In  input  1  0 stalls the FSM (holds all state) and blocks Start_In.
Clear_In  input  1  synchronous abort; forces IDLE and drops the current operation.
Start_In  input  1  request a compare; accepted only when Ready_Out=1 and Enable_In=1.
Signed_In  input  1  1 = two's-complement compare; captured together with the operands.
Data_A_In  input  DATA_WIDTH  operand A; captured on Start_In acceptance.
Data_B_In  input  DATA_WIDTH  operand B; captured on Start_In acceptance.
Ready_Out  output  1  1 in IDLE only.
Busy_Out  output  1  1 in COMPARE or DONE.
Valid_Out  output  1  one-cycle pulse; result flags are updated in this cycle.
A_gt_B_Out  output  1  registered result; held until the next Valid_Out.
A_eq_B_Out  output  1  registered result; held until the next Valid_Out.
A_lt_B_Out  output  1  registered result; held until the next Valid_Out.

Behaviour:
- Reset (async, any state): FSM = IDLE, chunk index = NUM_CHUNKS-1, operand regs = 0. Outputs: Valid_Out=0, all three flags 0, Busy_Out=0, Ready_Out=1.
- Priority at each edge: Reset_In > Clear_In > Enable_In=0 (stall) > normal operation.
- IDLE:
  - Start_In=1 and Enable_In=1: capture A, B and Signed, set index=NUM_CHUNKS-1, go to COMPARE.
  - If Signed=1, the MSB of each captured operand is inverted. The compare is then unsigned throughout.
- COMPARE, one chunk per cycle at slice [idx*CHUNK_WIDTH +: CHUNK_WIDTH]:
  - Chunks differ: latch gt/lt from that chunk and mark the result decided. Later chunks never overwrite a decided result.
  - Chunks equal: no change.
  - idx==0, or (early exit and decided): go to DONE. Otherwise idx decrements.
- DONE (one cycle):
  - Valid_Out=1.
  - Flags: decided -> gt or lt; undecided -> eq=1.
  - Exactly one flag is set.
  - Next state is IDLE.
- Latency, start accepted in cycle 0:
  - Full scan: Valid_Out in cycle NUM_CHUNKS+1. Defaults: cycle 5.
  - Minimum interval between accepted starts: NUM_CHUNKS+2 cycles.
- Start_In while Busy_Out=1: ignored, not queued. Operand inputs are don't-care outside acceptance.
- Clear_In mid-operation: IDLE next cycle, no Valid_Out, flags keep their previous result.
- Enable_In=0 in COMPARE/DONE: freeze. Valid_Out stays asserted for as long as DONE is held.
- NUM_CHUNKS=1: a single compare cycle, Valid_Out in cycle 2.

Optional Feature:
Macro COMPARATOR_SEQ_EARLY_EXIT_EN.
- Defined: COMPARE leaves for DONE on the first differing chunk. Latency is (number of chunks examined)+1, e.g. MSB chunk differs -> Valid_Out in cycle 2. Equal operands still take NUM_CHUNKS+1.
- Undefined: constant latency NUM_CHUNKS+1 for every operand pair. Results are identical in both builds.

Test Plan:
- Defaults, unsigned, A=0x00000001, B=0x00000000 -> gt=1, eq=0, lt=0; Valid_Out in cycle 5 with or without the macro, since the difference is in the LSB chunk.
- Unsigned, A=B=0xFFFFFFFF -> eq=1 in cycle 5. Signed, A=0x80000000, B=0x00000001 -> lt=1. The same operands unsigned -> gt=1.
- Macro defined, A=0xFF000000, B=0x00000000 -> gt=1, Valid_Out in cycle 2, Ready_Out=1 in cycle 3. Macro undefined -> Valid_Out in cycle 5.
- Start accepted, Clear_In=1 in cycle 2 -> Ready_Out=1 in cycle 3, no Valid_Out, flags unchanged. A second Start_In during Busy_Out is ignored.
- Enable_In=0 for 3 cycles during COMPARE -> Valid_Out delayed by exactly 3 cycles, result correct. Reset_In pulsed mid-COMPARE -> all outputs at reset values immediately (async).
- DATA_WIDTH=64, CHUNK_WIDTH=16: 10 random signed and unsigned pairs checked against a reference model -> 0 mismatches, exactly one flag set per Valid_Out.
